// File: rtl/alarm_clock_pkg.sv
// Shared constants and helpers for the 12-hour alarm-clock core.
// Segment codes are gfedcba, active high.
package alarm_clock_pkg;

   localparam logic [6:0] SEG_0 = 7'b0111111;
   localparam logic [6:0] SEG_1 = 7'b0000110;
   localparam logic [6:0] SEG_2 = 7'b1011011;
   localparam logic [6:0] SEG_3 = 7'b1001111;
   localparam logic [6:0] SEG_4 = 7'b1100110;
   localparam logic [6:0] SEG_5 = 7'b1101101;
   localparam logic [6:0] SEG_6 = 7'b1111101;
   localparam logic [6:0] SEG_7 = 7'b0000111;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1101111;
   localparam logic [6:0] BLANK = 7'b0000000;

   localparam logic [3:0] RST_HOUR = 4'd12;
   localparam logic [5:0] RST_MIN  = 6'd0;
   localparam int         SCAN_LEN = 33;

   // Returns {hour, pm}; 11->12 flips the half-day, 12->1 does not.
   function automatic logic [4:0] inc_hr(input logic [3:0] h,
                                         input logic       pm);
      if (h == 4'd12) return {4'd1, pm};
      return {h + 4'd1, pm ^ (h == 4'd11)};
   endfunction

   function automatic logic [5:0] inc_min(input logic [5:0] m);
      return (m == 6'd59) ? 6'd0 : m + 6'd1;
   endfunction

   // {tens_present, units} for an hour of 1..12.
   function automatic logic [4:0] hr_bcd(input logic [3:0] h);
      return (h >= 4'd10) ? {1'b1, h - 4'd10} : {1'b0, h};
   endfunction

   function automatic logic [7:0] min_bcd(input logic [5:0] m);
      logic [3:0] tens;
      if      (m >= 6'd50) tens = 4'd5;
      else if (m >= 6'd40) tens = 4'd4;
      else if (m >= 6'd30) tens = 4'd3;
      else if (m >= 6'd20) tens = 4'd2;
      else if (m >= 6'd10) tens = 4'd1;
      else                 tens = 4'd0;
      return {tens, 4'(m - 6'(tens) * 6'd10)};
   endfunction

endpackage

// File: rtl/alarm_clock_if.sv
// Pin bundle between the pad ring and the alarm-clock core.
// Clock and reset stay outside as plain ports.
interface alarm_clock_if;

   logic        SET_TIME;
   logic        ALARM;
   logic        HOURS;
   logic        MINUTES;
   logic        TOGGLE;
   logic        TEST_MODE;
   logic        TEST_SE;
   logic        TEST_SI;
   logic        SPEAKER;
   logic [13:0] HR;
   logic [13:0] MIN;
   logic        AM_PM;

   modport master (
      output SET_TIME, ALARM, HOURS, MINUTES, TOGGLE,
      output TEST_MODE, TEST_SE, TEST_SI,
      input  SPEAKER, HR, MIN, AM_PM
   );

   modport slave (
      input  SET_TIME, ALARM, HOURS, MINUTES, TOGGLE,
      input  TEST_MODE, TEST_SE, TEST_SI,
      output SPEAKER, HR, MIN, AM_PM
   );

endinterface

// File: rtl/seg7_decode.sv
// BCD digit to 7-segment (gfedcba, active high).
// Codes above 9 show blank.
module seg7_decode
   import alarm_clock_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = BLANK;
      unique case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = BLANK;
      endcase
   end

endmodule

// File: rtl/alarm_clock_core.sv
// 12-hour alarm clock with time/alarm edit, 7-seg display
// decode and a single full-scan chain ending at SPEAKER.
module alarm_clock_core
   import alarm_clock_pkg::*;
#(
   parameter int TICKS_PER_MIN = 60
) (
   input logic          CLOCK,
   input logic          RESETN,
   alarm_clock_if.slave bus
);

   localparam int PW = (TICKS_PER_MIN > 2) ? $clog2(TICKS_PER_MIN) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICKS_PER_MIN - 1);

   // Field order is the scan order: first field sits next to TEST_SI.
   typedef struct packed {
      logic          eh;
      logic          em;
      logic          et;
      logic [PW-1:0] presc;
      logic [3:0]    t_hr;
      logic [5:0]    t_min;
      logic          t_pm;
      logic [3:0]    a_hr;
      logic [5:0]    a_min;
      logic          a_pm;
      logic          en;
      logic          spk;
   } st_t;

   localparam int CHAIN = $bits(st_t);

   st_t              q;
   st_t              d;
   logic [CHAIN-1:0] qv;
   logic             rst;
   logic             he;
   logic             me;
   logic             te;
   logic             tick;
   logic             match;
   logic             show_alarm;
   logic [3:0]       src_hr;
   logic [5:0]       src_min;
   logic [4:0]       hb;
   logic [7:0]       mb;
   logic [6:0]       hr_t_seg;
   logic [6:0]       hr_u_seg;
   logic [6:0]       mn_t_seg;
   logic [6:0]       mn_u_seg;

   assign qv    = q;
   assign rst   = RESETN & ~bus.TEST_MODE;
   assign he    = bus.HOURS & ~q.eh;
   assign me    = bus.MINUTES & ~q.em;
   assign te    = bus.TOGGLE & ~q.et;
   assign match = (q.t_hr == q.a_hr) & (q.t_min == q.a_min) &
                  (q.t_pm == q.a_pm);

   always_comb begin
      d      = q;
      tick   = 1'b0;
      d.eh   = bus.HOURS;
      d.em   = bus.MINUTES;
      d.et   = bus.TOGGLE;
      if (bus.SET_TIME) begin
         d.presc = '0;
         if (he) {d.t_hr, d.t_pm} = inc_hr(q.t_hr, q.t_pm);
         if (me) d.t_min = inc_min(q.t_min);
      end else begin
         tick    = (q.presc == LAST);
         d.presc = tick ? '0 : q.presc + PW'(1);
         if (tick) begin
            d.t_min = inc_min(q.t_min);
            if (q.t_min == 6'd59)
               {d.t_hr, d.t_pm} = inc_hr(q.t_hr, q.t_pm);
         end
         if (bus.ALARM) begin
            if (he) {d.a_hr, d.a_pm} = inc_hr(q.a_hr, q.a_pm);
            if (me) d.a_min = inc_min(q.a_min);
         end
      end
      if (te) d.en = ~q.en;
      d.spk = q.en & ~bus.SET_TIME & match;
   end

   always_ff @(posedge CLOCK) begin
      if (rst) begin
         q       <= '0;
         q.t_hr  <= RST_HOUR;
         q.a_hr  <= RST_HOUR;
         q.t_min <= RST_MIN;
         q.a_min <= RST_MIN;
      end else if (bus.TEST_SE) begin
         q <= {bus.TEST_SI, qv[CHAIN-1:1]};
      end else begin
         q <= d;
      end
   end

   assign show_alarm = bus.ALARM & ~bus.SET_TIME;
   assign src_hr     = show_alarm ? q.a_hr  : q.t_hr;
   assign src_min    = show_alarm ? q.a_min : q.t_min;
   assign hb         = hr_bcd(src_hr);
   assign mb         = min_bcd(src_min);

   seg7_decode u_hr_t (.bcd({3'b000, hb[4]}), .seg(hr_t_seg));
   seg7_decode u_hr_u (.bcd(hb[3:0]),         .seg(hr_u_seg));
   seg7_decode u_mn_t (.bcd(mb[7:4]),         .seg(mn_t_seg));
   seg7_decode u_mn_u (.bcd(mb[3:0]),         .seg(mn_u_seg));

   assign bus.HR      = {hb[4] ? hr_t_seg : BLANK, hr_u_seg};
   assign bus.MIN     = {mn_t_seg, mn_u_seg};
   assign bus.AM_PM   = show_alarm ? q.a_pm : q.t_pm;
   assign bus.SPEAKER = q.spk;

endmodule

// File: tb/tb_alarm_clock_core.sv
// Bench for alarm_clock_core: directed steps plus random run
// against a minutes-of-day reference model.
module tb_alarm_clock_core;

   localparam int T = 2;

   logic CLOCK    = 1'b0;
   logic RESETN   = 1'b0;
   logic RESETN60 = 1'b0;

   always #5 CLOCK = ~CLOCK;

   alarm_clock_if bus ();
   alarm_clock_if bus60 ();

   alarm_clock_core #(.TICKS_PER_MIN(T)) dut (
      .CLOCK (CLOCK),
      .RESETN(RESETN),
      .bus   (bus)
   );

   alarm_clock_core dut60 (
      .CLOCK (CLOCK),
      .RESETN(RESETN60),
      .bus   (bus60)
   );

   int compared   = 0;
   int mismatched = 0;

   logic [6:0] seg [10] = '{7'b0111111, 7'b0000110, 7'b1011011,
                            7'b1001111, 7'b1100110, 7'b1101101,
                            7'b1111101, 7'b0000111, 7'b1111111,
                            7'b1101111};

   // Model: time and alarm as minutes since midnight, 0..1439.
   int m_t, m_a, m_pc;
   bit m_en, m_spk, m_ph, m_pmin, m_pt;
   bit hist [0:79];

   task automatic chk(input string tag, input logic [13:0] got,
                      input logic [13:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [13:0] hr_disp(input int v);
      int h;
      h = (v / 60) % 12;
      if (h == 0) h = 12;
      return {(h >= 10) ? seg[1] : 7'b0, seg[h % 10]};
   endfunction

   function automatic logic [13:0] min_disp(input int v);
      return {seg[(v % 60) / 10], seg[(v % 60) % 10]};
   endfunction

   function automatic int bump_min(input int v);
      return v - (v % 60) + ((v % 60) + 1) % 60;
   endfunction

   task automatic check_model(input string tag);
      int src;
      src = (bus.ALARM && !bus.SET_TIME) ? m_a : m_t;
      chk({tag, "_hr"},  bus.HR,  hr_disp(src));
      chk({tag, "_min"}, bus.MIN, min_disp(src));
      chk({tag, "_ampm"}, {13'b0, bus.AM_PM}, {13'b0, src >= 720});
      chk({tag, "_spk"}, {13'b0, bus.SPEAKER}, {13'b0, m_spk});
   endtask

   task automatic step(input string tag);
      bit s, al, h, mi, tg, r, he, me, te, nspk;
      s  = bus.SET_TIME;
      al = bus.ALARM;
      h  = bus.HOURS;
      mi = bus.MINUTES;
      tg = bus.TOGGLE;
      r  = RESETN && !bus.TEST_MODE;
      @(posedge CLOCK);
      #1;
      if (r) begin
         m_t = 0; m_a = 0; m_pc = 0;
         m_en = 0; m_spk = 0;
         m_ph = 0; m_pmin = 0; m_pt = 0;
      end else begin
         he   = h && !m_ph;
         me   = mi && !m_pmin;
         te   = tg && !m_pt;
         nspk = m_en && !s && (m_t == m_a);
         if (s) begin
            m_pc = 0;
            if (he) m_t = (m_t + 60) % 1440;
            if (me) m_t = bump_min(m_t);
         end else begin
            if (m_pc == T - 1) begin
               m_pc = 0;
               m_t  = (m_t + 1) % 1440;
            end else begin
               m_pc++;
            end
            if (al) begin
               if (he) m_a = (m_a + 60) % 1440;
               if (me) m_a = bump_min(m_a);
            end
         end
         if (te) m_en = !m_en;
         m_spk  = nspk;
         m_ph   = h;
         m_pmin = mi;
         m_pt   = tg;
      end
      check_model(tag);
   endtask

   task automatic do_reset();
      RESETN = 1'b1;
      step("rst");
      RESETN = 1'b0;
   endtask

   task automatic pulse_h(input string tag);
      bus.HOURS = 1'b1; step(tag);
      bus.HOURS = 1'b0; step(tag);
   endtask

   task automatic pulse_m(input string tag);
      bus.MINUTES = 1'b1; step(tag);
      bus.MINUTES = 1'b0; step(tag);
   endtask

   task automatic edge60();
      @(posedge CLOCK);
      #1;
   endtask

   initial begin
      {bus.SET_TIME, bus.ALARM, bus.HOURS, bus.MINUTES} = '0;
      {bus.TOGGLE, bus.TEST_MODE, bus.TEST_SE, bus.TEST_SI} = '0;
      {bus60.SET_TIME, bus60.ALARM, bus60.HOURS, bus60.MINUTES} = '0;
      {bus60.TOGGLE, bus60.TEST_MODE, bus60.TEST_SE, bus60.TEST_SI} = '0;
      #2;

      // Reset values
      do_reset();
      chk("reset_hr",  bus.HR,  14'b0000110_1011011);
      chk("reset_min", bus.MIN, 14'b0111111_0111111);
      chk("reset_ampm", {13'b0, bus.AM_PM}, 14'd0);
      chk("reset_spk",  {13'b0, bus.SPEAKER}, 14'd0);

      // One hour of running
      repeat (120) step("run");
      chk("run1h_hr",  bus.HR,  14'b0000000_0000110);
      chk("run1h_min", bus.MIN, 14'b0111111_0111111);
      chk("run1h_ampm", {13'b0, bus.AM_PM}, 14'd0);

      // 11:59 AM rolls to 12:00 PM
      do_reset();
      bus.SET_TIME = 1'b1;
      repeat (11) pulse_h("pre_h");
      repeat (59) pulse_m("pre_m");
      bus.SET_TIME = 1'b0;
      step("roll");
      step("roll");
      chk("noon_hr",  bus.HR,  14'b0000110_1011011);
      chk("noon_min", bus.MIN, 14'b0111111_0111111);
      chk("noon_ampm", {13'b0, bus.AM_PM}, 14'd1);

      // Set-time edits
      do_reset();
      bus.SET_TIME = 1'b1;
      repeat (11) pulse_h("set_h");
      chk("set11_hr", bus.HR, 14'b0000110_0000110);
      pulse_h("set_h");
      chk("set12_hr", bus.HR, 14'b0000110_1011011);
      chk("set12_ampm", {13'b0, bus.AM_PM}, 14'd1);
      bus.HOURS = 1'b1;
      repeat (3) step("hold");
      bus.HOURS = 1'b0;
      step("hold");
      repeat (60) pulse_m("set_m");
      chk("setm_min", bus.MIN, 14'b0111111_0111111);
      chk("setm_hr",  bus.HR,  14'b0000000_0000110);
      bus.SET_TIME = 1'b0;

      // Alarm ring at 12:01 AM
      do_reset();
      bus.ALARM = 1'b1; bus.MINUTES = 1'b1;
      step("ring");
      bus.ALARM = 1'b0; bus.MINUTES = 1'b0; bus.TOGGLE = 1'b1;
      step("ring");
      bus.TOGGLE = 1'b0;
      step("ring");
      chk("ring_on1", {13'b0, bus.SPEAKER}, 14'd1);
      step("ring");
      chk("ring_on2", {13'b0, bus.SPEAKER}, 14'd1);
      step("ring");
      chk("ring_off", {13'b0, bus.SPEAKER}, 14'd0);

      // Mid-ring toggle, short minutes
      do_reset();
      bus.ALARM = 1'b1; bus.MINUTES = 1'b1;
      step("tog");
      bus.ALARM = 1'b0; bus.MINUTES = 1'b0; bus.TOGGLE = 1'b1;
      step("tog");
      bus.TOGGLE = 1'b0;
      step("tog");
      bus.TOGGLE = 1'b1;
      step("tog");
      bus.TOGGLE = 1'b0;
      repeat (4) step("tog");

      // Mid-ring toggle, 60-tick minutes
      RESETN60 = 1'b1;
      edge60();
      RESETN60 = 1'b0;
      chk("r60_hr", bus60.HR, 14'b0000110_1011011);
      bus60.ALARM = 1'b1; bus60.MINUTES = 1'b1;
      edge60();
      bus60.ALARM = 1'b0; bus60.MINUTES = 1'b0; bus60.TOGGLE = 1'b1;
      edge60();
      bus60.TOGGLE = 1'b0;
      repeat (58) edge60();
      chk("r60_pre", {13'b0, bus60.SPEAKER}, 14'd0);
      chk("r60_min", bus60.MIN, 14'b0111111_0000110);
      edge60();
      chk("r60_on", {13'b0, bus60.SPEAKER}, 14'd1);
      repeat (9) edge60();
      chk("r60_hold", {13'b0, bus60.SPEAKER}, 14'd1);
      bus60.TOGGLE = 1'b1;
      edge60();
      chk("r60_tog", {13'b0, bus60.SPEAKER}, 14'd1);
      bus60.TOGGLE = 1'b0;
      edge60();
      chk("r60_off", {13'b0, bus60.SPEAKER}, 14'd0);

      // Scan shift under asserted reset, both chain lengths
      RESETN = 1'b1; RESETN60 = 1'b1;
      bus.TEST_MODE = 1'b1; bus.TEST_SE = 1'b1;
      bus60.TEST_MODE = 1'b1; bus60.TEST_SE = 1'b1;
      for (int j = 0; j < 80; j++) begin
         hist[j] = 1'($urandom);
         bus.TEST_SI = hist[j];
         bus60.TEST_SI = hist[j];
         edge60();
         if (j >= 27)
            chk("scan28", {13'b0, bus.SPEAKER}, {13'b0, hist[j-27]});
         if (j >= 32)
            chk("scan33", {13'b0, bus60.SPEAKER}, {13'b0, hist[j-32]});
      end
      bus.TEST_MODE = 1'b0; bus.TEST_SE = 1'b0; bus.TEST_SI = 1'b0;
      bus60.TEST_MODE = 1'b0; bus60.TEST_SE = 1'b0;
      RESETN = 1'b0; RESETN60 = 1'b0;

      // Random operation
      do_reset();
      for (int k = 0; k < 800; k++) begin
         bus.SET_TIME  = ($urandom_range(0, 9) == 0);
         bus.ALARM     = ($urandom_range(0, 2) == 0);
         bus.HOURS     = ($urandom_range(0, 2) == 0);
         bus.MINUTES   = ($urandom_range(0, 2) == 0);
         bus.TOGGLE    = ($urandom_range(0, 7) == 0);
         bus.TEST_MODE = ($urandom_range(0, 9) == 0);
         RESETN        = ($urandom_range(0, 99) == 0);
         step("rand");
      end
      RESETN = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
